// File: rtl/tage_update_sched.sv
// Update scheduler for the TAGE predictor's single update port: an in-order queue
// fed by several commit lanes, drained one update per cycle, with flush and drain control.
module tage_update_sched #(
    parameter  int NUM_LANES = 2,
    parameter  int DEPTH     = 8,
    parameter  int CNT_W     = 16,
    localparam int OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_LANES-1:0]    res_valid_i,
    input  logic [NUM_LANES*64-1:0] res_pc_i,
    input  logic [NUM_LANES-1:0]    res_taken_i,
    output logic                    res_ready_o,
    output logic                    upd_valid_o,
    output logic [63:0]             upd_pc_o,
    output logic                    upd_taken_o,
    input  logic                    upd_ready_i,
    input  logic                    flush_i,
    input  logic                    drain_i,
    output logic                    drain_done_o,
    output logic [OCC_W-1:0]        occupancy_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LN_W  = $clog2(NUM_LANES + 1);
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    logic [63:0]          pc_q [DEPTH];
    logic [DEPTH-1:0]     taken_q;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    state_e               state_q, state_d;

    logic                 accept_s;
    logic                 upd_valid_s;
    logic                 deq_s;
    logic [NUM_LANES-1:0] lane_wen_s;
    logic [PTR_W-1:0]     lane_idx_s [NUM_LANES];
    logic [LN_W-1:0]      n_enq_s;
    logic [SUM_W-1:0]     drop_sum_s;

    // Intake and issue handshakes, both gated by flush and reset.
    always_comb begin
        accept_s    = !rst && (state_q == ST_RUN) && !flush_i &&
                      ((OCC_W'(DEPTH) - count_q) >= OCC_W'(NUM_LANES));
        upd_valid_s = !rst && (count_q != OCC_W'(0)) && !flush_i;
        deq_s       = upd_valid_s && upd_ready_i;
    end

    // Valid lanes take consecutive slots from wr_ptr; invalid lanes leave no gap.
    always_comb begin
        n_enq_s = LN_W'(0);
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_wen_s[i] = accept_s && res_valid_i[i];
            lane_idx_s[i] = wr_ptr_q + PTR_W'(n_enq_s);
            if (lane_wen_s[i]) begin
                n_enq_s = n_enq_s + LN_W'(1);
            end else begin
                n_enq_s = n_enq_s;
            end
        end
    end

    // Payload storage; contents are only observed through occupied slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_wen_s[i]) begin
                pc_q[lane_idx_s[i]]    <= res_pc_i[64*i +: 64];
                taken_q[lane_idx_s[i]] <= res_taken_i[i];
            end
        end
    end

    // Pointer, count and drop-counter next state; flush overrides any transfer.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        drop_sum_s = SUM_W'(drop_q) + SUM_W'(count_q);
        if (flush_i) begin
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
            count_d  = OCC_W'(0);
            if (drop_sum_s > SUM_W'({CNT_W{1'b1}})) begin
                drop_d = {CNT_W{1'b1}};
            end else begin
                drop_d = drop_sum_s[CNT_W-1:0];
            end
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(deq_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(n_enq_s);
            count_d  = count_q + OCC_W'(n_enq_s) - OCC_W'(deq_s);
        end
    end

    // Drain sequencing: DRAIN exits once the registered count is zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (count_q == OCC_W'(0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            count_q  <= OCC_W'(0);
            drop_q   <= {CNT_W{1'b0}};
            state_q  <= ST_RUN;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
        end
    end

    assign res_ready_o  = accept_s;
    assign upd_valid_o  = upd_valid_s;
    assign upd_pc_o     = pc_q[rd_ptr_q];
    assign upd_taken_o  = taken_q[rd_ptr_q];
    assign drain_done_o = (state_q == ST_DONE) && !rst;
    assign occupancy_o  = count_q;
    assign drop_cnt_o   = drop_q;

endmodule
